// File: rtl/sin_nco_sched.sv
// Multi-channel NCO scheduler sharing one registered sin_table lookup round-robin.
// Optional phase dither LFSR enabled by defining SIN_NCO_DITHER_EN.
`timescale 1ns/1ps
module sin_nco_sched #(
    parameter int unsigned CHW = 2,
    parameter int unsigned AW  = 32,
    parameter int unsigned PW  = 17,
    parameter int unsigned OW  = 13
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_cfg_wr,
    input  logic                   i_cfg_sel,
    input  logic [CHW-1:0]         i_cfg_ch,
    input  logic [AW-1:0]          i_cfg_data,
    input  logic [(1 << CHW)-1:0]  i_en,
    input  logic                   i_sync,
    output logic                   o_tbl_ce,
    output logic [PW-1:0]          o_tbl_phase,
    input  logic [OW-1:0]          i_tbl_val,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [CHW-1:0]         o_ch,
    output logic [OW-1:0]          o_sample
);
    localparam int unsigned NCH = 1 << CHW;

    logic [AW-1:0]  acc_q  [NCH];
    logic [AW-1:0]  acc_d  [NCH];
    logic [AW-1:0]  freq_q [NCH];
    logic [AW-1:0]  freq_d [NCH];
    logic [AW-1:0]  offs_q [NCH];
    logic [AW-1:0]  offs_d [NCH];
    logic [CHW-1:0] ptr_q, ptr_d;
    logic           a_valid_q, a_valid_d;
    logic [CHW-1:0] a_ch_q, a_ch_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic           o_valid_q, o_valid_d;
    logic [CHW-1:0] o_ch_q, o_ch_d;

    logic           pipe_ce_c;
    logic           any_en_c;
    logic [CHW-1:0] sel_c;
    logic [CHW-1:0] cand_c;
    logic           found_c;
    logic [AW-1:0]  sum_c;
    logic [AW-1:0]  dither_c;

    assign pipe_ce_c = !o_valid_q || i_ready;
    assign any_en_c  = |i_en;

`ifdef SIN_NCO_DITHER_EN
    localparam logic [AW-1:0] DMASK = AW'((65'(1) << (AW - PW)) - 65'(1));
    logic [15:0] lfsr_q, lfsr_d;

    // x^16+x^14+x^13+x^11+1, advances with the pipeline
    always_comb begin
        lfsr_d = lfsr_q;
        if (pipe_ce_c) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dither_c = AW'(lfsr_q) & DMASK;
`else
    assign dither_c = '0;
`endif

    // First enabled channel after the last issued one, cyclically
    always_comb begin
        sel_c   = ptr_q;
        found_c = 1'b0;
        cand_c  = ptr_q;
        for (int unsigned k = 1; k <= NCH; k++) begin
            cand_c = ptr_q + CHW'(k);
            if (!found_c && i_en[cand_c]) begin
                sel_c   = cand_c;
                found_c = 1'b1;
            end
        end
    end

    assign sum_c = acc_q[sel_c] + offs_q[sel_c] + dither_c;

    always_comb begin
        acc_d     = acc_q;
        freq_d    = freq_q;
        offs_d    = offs_q;
        ptr_d     = ptr_q;
        a_valid_d = a_valid_q;
        a_ch_d    = a_ch_q;
        phase_d   = phase_q;
        o_valid_d = o_valid_q;
        o_ch_d    = o_ch_q;

        if (i_cfg_wr) begin
            if (i_cfg_sel) begin
                offs_d[i_cfg_ch] = i_cfg_data;
            end else begin
                freq_d[i_cfg_ch] = i_cfg_data;
            end
        end

        if (pipe_ce_c) begin
            a_valid_d = any_en_c;
            a_ch_d    = sel_c;
            phase_d   = PW'(sum_c >> (AW - PW));
            o_valid_d = a_valid_q;
            o_ch_d    = a_ch_q;
            if (any_en_c) begin
                acc_d[sel_c] = acc_q[sel_c] + freq_q[sel_c];
                ptr_d        = sel_c;
            end
        end

        // Sync overrides the issue-side accumulator update
        if (i_sync) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                acc_d[k] = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                acc_q[k]  <= '0;
                freq_q[k] <= '0;
                offs_q[k] <= '0;
            end
            ptr_q     <= CHW'(NCH - 1);
            a_valid_q <= 1'b0;
            a_ch_q    <= '0;
            phase_q   <= '0;
            o_valid_q <= 1'b0;
            o_ch_q    <= '0;
        end else begin
            acc_q     <= acc_d;
            freq_q    <= freq_d;
            offs_q    <= offs_d;
            ptr_q     <= ptr_d;
            a_valid_q <= a_valid_d;
            a_ch_q    <= a_ch_d;
            phase_q   <= phase_d;
            o_valid_q <= o_valid_d;
            o_ch_q    <= o_ch_d;
        end
    end

    assign o_tbl_ce    = pipe_ce_c;
    assign o_tbl_phase = phase_q;
    assign o_valid     = o_valid_q;
    assign o_ch        = o_ch_q;
    assign o_sample    = i_tbl_val;

endmodule

// File: tb/tb_sin_nco_sched.sv
// Scoreboard bench for sin_nco_sched with a stand-in registered lookup table.
`timescale 1ns/1ps
module tb_sin_nco_sched;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_cfg_wr;
    logic        i_cfg_sel;
    logic [1:0]  i_cfg_ch;
    logic [31:0] i_cfg_data;
    logic [3:0]  i_en;
    logic        i_sync;
    logic        o_tbl_ce;
    logic [16:0] o_tbl_phase;
    logic [12:0] i_tbl_val = '0;
    logic        o_valid;
    logic        i_ready;
    logic [1:0]  o_ch;
    logic [12:0] o_sample;

    typedef struct packed {
        logic [1:0]  ch;
        logic [16:0] ph;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b1;

    always #5 i_clk = ~i_clk;

    sin_nco_sched dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_cfg_wr(i_cfg_wr), .i_cfg_sel(i_cfg_sel),
        .i_cfg_ch(i_cfg_ch), .i_cfg_data(i_cfg_data), .i_en(i_en), .i_sync(i_sync),
        .o_tbl_ce(o_tbl_ce), .o_tbl_phase(o_tbl_phase), .i_tbl_val(i_tbl_val),
        .o_valid(o_valid), .i_ready(i_ready), .o_ch(o_ch), .o_sample(o_sample)
    );

    function automatic logic [12:0] lut(input logic [16:0] p);
        return p[16:4] ^ {9'b0, p[3:0]};
    endfunction

    // Stand-in for sin_table: one-cycle registered lookup gated by i_ce
    always @(posedge i_clk) begin
        if (o_tbl_ce) i_tbl_val <= lut(o_tbl_phase);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] ch, input logic [16:0] ph);
        exp_t e;
        e.ch = ch;
        e.ph = ph;
        sb_q.push_back(e);
    endtask

    // Monitor: pop one expectation per accepted sample
    always @(negedge i_clk) begin
        if (mon_en && o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: actual ch=%0d sample=0x%0h required=none", o_ch, o_sample);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_ch", 32'(o_ch), 32'(e.ch));
                chk("sb_sample", 32'(o_sample), 32'(lut(e.ph)));
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_en    = '0;
        i_sync  = 1'b0;
        i_ready = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ch", 32'(o_ch), 32'd0);
        chk("rst_phase", 32'(o_tbl_phase), 32'd0);
    endtask

    task automatic cfg(input logic s, input logic [1:0] ch, input logic [31:0] d);
        i_cfg_wr   = 1'b1;
        i_cfg_sel  = s;
        i_cfg_ch   = ch;
        i_cfg_data = d;
        tick();
        i_cfg_wr   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
        chk("sb_drain_left", 32'(sb_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        #200_000;
        $display("FAIL global_timeout: actual=expired required=finished");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        i_reset = 1'b1; i_cfg_wr = 1'b0; i_cfg_sel = 1'b0; i_cfg_ch = '0;
        i_cfg_data = '0; i_en = '0; i_sync = 1'b0; i_ready = 1'b1;
        tick();
        do_reset();

        // Single channel ramp and latency
        cfg(1'b0, 2'd0, 32'h0100_0000);
        for (int i = 0; i < 6; i++) push(2'd0, 17'(i * 32'h200));
        i_en = 4'b0001;
        tick();
        chk("lat_valid_c1", 32'(o_valid), 32'd0);
        chk("lat_phase_c1", 32'(o_tbl_phase), 32'h0);
        tick();
        chk("lat_valid_c2", 32'(o_valid), 32'd1);
        chk("lat_phase_c2", 32'(o_tbl_phase), 32'h200);
        repeat (4) tick();
        i_en = '0;
        drain();

        // Round robin over a sparse mask, then channel 2 untouched
        do_reset();
        cfg(1'b0, 2'd0, 32'h0100_0000);
        cfg(1'b0, 2'd1, 32'h0200_0000);
        cfg(1'b0, 2'd2, 32'h0300_0000);
        cfg(1'b0, 2'd3, 32'h0400_0000);
        push(2'd0, 17'h0);   push(2'd1, 17'h0);   push(2'd3, 17'h0);
        push(2'd0, 17'h200); push(2'd1, 17'h400); push(2'd3, 17'h800);
        push(2'd2, 17'h0);
        i_en = 4'b1011;
        repeat (6) tick();
        i_en = 4'b0100;
        tick();
        i_en = '0;
        drain();

        // Backpressure hold
        do_reset();
        cfg(1'b0, 2'd0, 32'h0100_0000);
        push(2'd0, 17'h0); push(2'd0, 17'h200); push(2'd0, 17'h400); push(2'd0, 17'h600);
        i_en = 4'b0001;
        tick();
        tick();
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(o_valid), 32'd1);
            chk("stall_ch", 32'(o_ch), 32'd0);
            chk("stall_sample", 32'(o_sample), 32'(lut(17'h0)));
            chk("stall_phase", 32'(o_tbl_phase), 32'h200);
        end
        i_ready = 1'b1;
        tick();
        tick();
        i_en = '0;
        drain();

        // Accumulator wrap and offset
        do_reset();
        cfg(1'b0, 2'd1, 32'hFFFF_FFFF);
        cfg(1'b1, 2'd1, 32'h8000_0000);
        push(2'd1, 17'h10000); push(2'd1, 17'h0FFFF); push(2'd1, 17'h0FFFF);
        i_en = 4'b0010;
        repeat (3) tick();
        i_en = '0;
        drain();

        // Sync mid-stream
        do_reset();
        cfg(1'b0, 2'd0, 32'h0100_0000);
        cfg(1'b1, 2'd0, 32'h0010_0000);
        push(2'd0, 17'h20);  push(2'd0, 17'h220); push(2'd0, 17'h420);
        push(2'd0, 17'h20);  push(2'd0, 17'h220);
        i_en = 4'b0001;
        tick();
        tick();
        i_sync = 1'b1;
        tick();
        i_sync = 1'b0;
        tick();
        tick();
        i_en = '0;
        drain();

        // Reset beats sync and flushes both stages
        mon_en = 1'b0;
        i_en = 4'b0001;
        repeat (3) tick();
        chk("pre_rst_valid", 32'(o_valid), 32'd1);
        i_reset = 1'b1;
        i_sync  = 1'b1;
        tick();
        chk("rstsync_valid", 32'(o_valid), 32'd0);
        chk("rstsync_ch", 32'(o_ch), 32'd0);
        chk("rstsync_phase", 32'(o_tbl_phase), 32'd0);
        i_reset = 1'b0;
        i_sync  = 1'b0;
        i_en    = '0;
        tick();
        chk("rstsync_flush", 32'(o_valid), 32'd0);
        mon_en = 1'b1;

        // Frequency write on the same edge as its own issue
        do_reset();
        cfg(1'b0, 2'd0, 32'h0100_0000);
        push(2'd0, 17'h0); push(2'd0, 17'h200); push(2'd0, 17'h600);
        i_en       = 4'b0001;
        i_cfg_wr   = 1'b1;
        i_cfg_sel  = 1'b0;
        i_cfg_ch   = 2'd0;
        i_cfg_data = 32'h0200_0000;
        tick();
        i_cfg_wr = 1'b0;
        tick();
        tick();
        i_en = '0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
